// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared widths and constants for the architectural register file and its
//   read ports.
//   XLEN     : architectural data width
//   ROB_ID_W : reorder-buffer id width (id 0 = no pending writer)
//   NO_DEP   : tag value meaning "value is architectural"
//   REG_ZERO : hard-wired zero register index
package register_file_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ROB_ID_W = 5;
    localparam int unsigned NO_DEP   = 0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage : register_file_pkg

// File: rtl/rf_read_port.sv
// rf_read_port
//   One combinational source-operand lookup: returns the pending-writer tag
//   and architectural value of i_ask_rd, with a bypass of the commit being
//   retired in the same cycle.
//   i_regs / i_tags      : current register file state
//   i_commit_en          : commit valid and global ready both high
//   i_commit_rd          : destination register of the commit
//   i_commit_rob_id      : ROB id being retired
//   i_commit_value       : retired value
//   i_ask_rd             : queried source register
//   o_dep                : pending-writer tag, 0 if none
//   o_value              : architectural value (meaningful when o_dep == 0)
module rf_read_port #(
    parameter int unsigned XLEN     = register_file_pkg::XLEN,
    parameter int unsigned ROB_ID_W = register_file_pkg::ROB_ID_W
) (
    input  logic [XLEN-1:0]     i_regs [32],
    input  logic [ROB_ID_W-1:0] i_tags [32],
    input  logic                i_commit_en,
    input  logic [4:0]          i_commit_rd,
    input  logic [ROB_ID_W-1:0] i_commit_rob_id,
    input  logic [XLEN-1:0]     i_commit_value,
    input  logic [4:0]          i_ask_rd,
    output logic [ROB_ID_W-1:0] o_dep,
    output logic [XLEN-1:0]     o_value
);
    import register_file_pkg::*;

    logic                w_bypass;
    logic [ROB_ID_W-1:0] w_tag;

    always_comb begin
        w_tag    = i_tags[i_ask_rd];
        // Forward only when the retiring instruction is still the youngest
        // writer; otherwise a younger rename keeps the operand pending.
        w_bypass = i_commit_en
                && (i_commit_rd == i_ask_rd)
                && (i_ask_rd != REG_ZERO)
                && (w_tag == i_commit_rob_id);
    end

    always_comb begin
        o_dep   = ROB_ID_W'(NO_DEP);
        o_value = '0;
        if (i_ask_rd == REG_ZERO) begin
            o_dep   = ROB_ID_W'(NO_DEP);
            o_value = '0;
        end else if (w_bypass) begin
            o_dep   = ROB_ID_W'(NO_DEP);
            o_value = i_commit_value;
        end else begin
            o_dep   = w_tag;
            o_value = i_regs[i_ask_rd];
        end
    end

endmodule : rf_read_port

// File: rtl/register_file.sv
// register_file
//   Architectural register file x0..x31 with per-register rename tags
//   (ROB id of the youngest in-flight writer). Records launch renames,
//   retires committed values, drops all tags on flush, and answers two
//   combinational source-operand queries per cycle.
//   clk_in / rst_in            : clock, asynchronous active-high reset
//   rdy_in                     : global ready, state holds when low
//   _clear                     : flush, zeroes every tag
//   _rf_launch_*               : rename request (valid, ROB id, rd)
//   _rf_commit_*               : retire request (valid, ROB id, rd, value)
//   _ask_rd_1/_2               : queried source registers
//   _dep_rd_1/_2               : pending-writer tags, 0 if none
//   _dep_value_1/_2            : architectural values
module register_file #(
    parameter int unsigned XLEN     = register_file_pkg::XLEN,
    parameter int unsigned ROB_ID_W = register_file_pkg::ROB_ID_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _rf_launch_ready,
    input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
    input  logic [4:0]          _rf_launch_register_id,
    input  logic                _rf_commit_ready,
    input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
    input  logic [4:0]          _rf_commit_register_id,
    input  logic [XLEN-1:0]     _rf_commit_value,
    input  logic [4:0]          _ask_rd_1,
    input  logic [4:0]          _ask_rd_2,
    output logic [ROB_ID_W-1:0] _dep_rd_1,
    output logic [ROB_ID_W-1:0] _dep_rd_2,
    output logic [XLEN-1:0]     _dep_value_1,
    output logic [XLEN-1:0]     _dep_value_2
);
    import register_file_pkg::*;

    logic [XLEN-1:0]     r_regs [32];
    logic [ROB_ID_W-1:0] r_tags [32];

    logic w_commit_en;
    logic w_commit_wr;
    logic w_launch_wr;

    always_comb begin
        w_commit_en = _rf_commit_ready && rdy_in;
        w_commit_wr = w_commit_en && (_rf_commit_register_id != REG_ZERO);
        w_launch_wr = _rf_launch_ready && rdy_in && !_clear
                   && (_rf_launch_register_id != REG_ZERO);
    end

    // Index 0 is only ever written by reset, so x0 stays 0/0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
                r_tags[i] <= '0;
            end
        end else if (rdy_in) begin
            if (w_commit_wr) begin
                r_regs[_rf_commit_register_id] <= _rf_commit_value;
            end
            // Priority per tag: flush, then launch rename, then commit clear.
            // Launch beating the clear keeps a same-cycle younger rename.
            for (int unsigned i = 1; i < 32; i++) begin
                if (_clear) begin
                    r_tags[i] <= ROB_ID_W'(NO_DEP);
                end else if (w_launch_wr && (_rf_launch_register_id == 5'(i))) begin
                    r_tags[i] <= _rf_launch_rob_id;
                end else if (w_commit_wr && (_rf_commit_register_id == 5'(i))
                             && (r_tags[i] == _rf_commit_rob_id)) begin
                    r_tags[i] <= ROB_ID_W'(NO_DEP);
                end
            end
        end
    end

    rf_read_port #(
        .XLEN     (XLEN),
        .ROB_ID_W (ROB_ID_W)
    ) u_port_1 (
        .i_regs          (r_regs),
        .i_tags          (r_tags),
        .i_commit_en     (w_commit_en),
        .i_commit_rd     (_rf_commit_register_id),
        .i_commit_rob_id (_rf_commit_rob_id),
        .i_commit_value  (_rf_commit_value),
        .i_ask_rd        (_ask_rd_1),
        .o_dep           (_dep_rd_1),
        .o_value         (_dep_value_1)
    );

    rf_read_port #(
        .XLEN     (XLEN),
        .ROB_ID_W (ROB_ID_W)
    ) u_port_2 (
        .i_regs          (r_regs),
        .i_tags          (r_tags),
        .i_commit_en     (w_commit_en),
        .i_commit_rd     (_rf_commit_register_id),
        .i_commit_rob_id (_rf_commit_rob_id),
        .i_commit_value  (_rf_commit_value),
        .i_ask_rd        (_ask_rd_2),
        .o_dep           (_dep_rd_2),
        .o_value         (_dep_value_2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ROB_ID_W = 5;

    logic                clk_in;
    logic                rst_in;
    logic                rdy_in;
    logic                _clear;
    logic                _rf_launch_ready;
    logic [ROB_ID_W-1:0] _rf_launch_rob_id;
    logic [4:0]          _rf_launch_register_id;
    logic                _rf_commit_ready;
    logic [ROB_ID_W-1:0] _rf_commit_rob_id;
    logic [4:0]          _rf_commit_register_id;
    logic [XLEN-1:0]     _rf_commit_value;
    logic [4:0]          _ask_rd_1;
    logic [4:0]          _ask_rd_2;
    logic [ROB_ID_W-1:0] _dep_rd_1;
    logic [ROB_ID_W-1:0] _dep_rd_2;
    logic [XLEN-1:0]     _dep_value_1;
    logic [XLEN-1:0]     _dep_value_2;

    register_file #(
        .XLEN     (XLEN),
        .ROB_ID_W (ROB_ID_W)
    ) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        ._clear                 (_clear),
        ._rf_launch_ready       (_rf_launch_ready),
        ._rf_launch_rob_id      (_rf_launch_rob_id),
        ._rf_launch_register_id (_rf_launch_register_id),
        ._rf_commit_ready       (_rf_commit_ready),
        ._rf_commit_rob_id      (_rf_commit_rob_id),
        ._rf_commit_register_id (_rf_commit_register_id),
        ._rf_commit_value       (_rf_commit_value),
        ._ask_rd_1              (_ask_rd_1),
        ._ask_rd_2              (_ask_rd_2),
        ._dep_rd_1              (_dep_rd_1),
        ._dep_rd_2              (_dep_rd_2),
        ._dep_value_1           (_dep_value_1),
        ._dep_value_2           (_dep_value_2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic                lv;
        logic [ROB_ID_W-1:0] lid;
        logic [4:0]          lrd;
        logic                cv;
        logic [ROB_ID_W-1:0] cid;
        logic [4:0]          crd;
        logic [XLEN-1:0]     cval;
        logic                clr;
        logic                rdy;
        logic [4:0]          a1;
        logic [4:0]          a2;
        logic [ROB_ID_W-1:0] d1;
        logic [XLEN-1:0]     v1;
        logic [ROB_ID_W-1:0] d2;
        logic [XLEN-1:0]     v2;
    } vec_t;

    typedef struct {
        int                  tagno;
        logic [ROB_ID_W-1:0] d1;
        logic [XLEN-1:0]     v1;
        logic [ROB_ID_W-1:0] d2;
        logic [XLEN-1:0]     v2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic lv, input int lid, input int lrd,
        input logic cv, input int cid, input int crd, input logic [XLEN-1:0] cval,
        input logic clr, input logic rdy, input int a1, input int a2,
        input int d1, input logic [XLEN-1:0] v1, input int d2, input logic [XLEN-1:0] v2);
        vec_t v;
        v.lv = lv;   v.lid = ROB_ID_W'(lid); v.lrd = 5'(lrd);
        v.cv = cv;   v.cid = ROB_ID_W'(cid); v.crd = 5'(crd); v.cval = cval;
        v.clr = clr; v.rdy = rdy; v.a1 = 5'(a1); v.a2 = 5'(a2);
        v.d1 = ROB_ID_W'(d1); v.v1 = v1; v.d2 = ROB_ID_W'(d2); v.v2 = v2;
        return v;
    endfunction

    task automatic idle_inputs();
        rdy_in = 1'b1; _clear = 1'b0;
        _rf_launch_ready = 1'b0; _rf_launch_rob_id = '0; _rf_launch_register_id = '0;
        _rf_commit_ready = 1'b0; _rf_commit_rob_id = '0; _rf_commit_register_id = '0;
        _rf_commit_value = '0;
    endtask

    task automatic push_exp(input int tagno, input int d1, input logic [XLEN-1:0] v1,
                            input int d2, input logic [XLEN-1:0] v2);
        exp_t e;
        e.tagno = tagno;
        e.d1 = ROB_ID_W'(d1); e.v1 = v1; e.d2 = ROB_ID_W'(d2); e.v2 = v2;
        sb.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        checks += 4;
        if (_dep_rd_1 !== e.d1) begin
            errors++;
            $display("FAIL step%0d dep1 got %0d want %0d", e.tagno, _dep_rd_1, e.d1);
        end
        if (_dep_value_1 !== e.v1) begin
            errors++;
            $display("FAIL step%0d value1 got 0x%0h want 0x%0h", e.tagno, _dep_value_1, e.v1);
        end
        if (_dep_rd_2 !== e.d2) begin
            errors++;
            $display("FAIL step%0d dep2 got %0d want %0d", e.tagno, _dep_rd_2, e.d2);
        end
        if (_dep_value_2 !== e.v2) begin
            errors++;
            $display("FAIL step%0d value2 got 0x%0h want 0x%0h", e.tagno, _dep_value_2, e.v2);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        _ask_rd_1 = 5'd5; _ask_rd_2 = 5'd6;

        // Columns: lv lid lrd | cv cid crd cval | clr rdy | a1 a2 | d1 v1 d2 v2
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 5,6,  0,'0,       0,'0));     // 0 reset state
        vecs.push_back(mk(1,7,3,   0,0,0,'0,       0,1, 3,0,  0,'0,       0,'0));     // 1 launch x3 id7
        vecs.push_back(mk(0,0,0,   1,7,3,'h1234,   0,1, 3,3,  0,'h1234,   0,'h1234)); // 2 commit bypass
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 3,4,  0,'h1234,   0,'0));     // 3 from state
        vecs.push_back(mk(1,2,4,   0,0,0,'0,       0,1, 4,4,  0,'0,       0,'0));     // 4 launch x4 id2
        vecs.push_back(mk(1,9,4,   0,0,0,'0,       0,1, 4,0,  2,'0,       0,'0));     // 5 launch x4 id9
        vecs.push_back(mk(0,0,0,   1,2,4,'hAA,     0,1, 4,3,  9,'0,       0,'h1234)); // 6 stale commit
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 4,0,  9,'hAA,     0,'0));     // 7 tag survives
        vecs.push_back(mk(1,3,8,   1,3,8,'d5,      0,1, 8,8,  0,'0,       0,'0));     // 8 launch+commit x8
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 8,0,  3,'d5,      0,'0));     // 9 launch wins
        for (int k = 0; k < 10; k++) begin                                            // 10..19
            vecs.push_back(mk(1,k+1,k+1, 0,0,0,'0, 0,1, 3,8,
                              (k >= 3) ? 3 : 0, 'h1234,
                              (k >= 8) ? 8 : 3, 'd5));
        end
        vecs.push_back(mk(1,11,11, 0,0,0,'0,       1,1, 4,10, 4,'hAA,     10,'0));    // 20 clear+launch
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 4,11, 0,'hAA,     0,'0));     // 21 tags cleared
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 3,8,  0,'h1234,   0,'d5));    // 22 values kept
        vecs.push_back(mk(1,5,0,   1,5,0,'hFFFF,   0,1, 0,0,  0,'0,       0,'0));     // 23 x0 writes
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 0,0,  0,'0,       0,'0));     // 24 x0 still 0
        vecs.push_back(mk(1,4,2,   0,0,0,'0,       0,0, 2,0,  0,'0,       0,'0));     // 25 rdy low launch
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 2,0,  0,'0,       0,'0));     // 26 tag x2 held
        vecs.push_back(mk(1,6,5,   0,0,0,'0,       0,1, 5,0,  0,'0,       0,'0));     // 27 launch x5 id6
        vecs.push_back(mk(0,0,0,   1,6,5,'h77,     0,0, 5,5,  6,'0,       6,'0));     // 28 rdy low, no bypass
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 5,0,  6,'0,       0,'0));     // 29 commit ignored
        vecs.push_back(mk(0,0,0,   1,6,5,'h77,     0,1, 5,0,  0,'h77,     0,'0));     // 30 bypass
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 5,0,  0,'h77,     0,'0));     // 31 committed
        vecs.push_back(mk(1,12,6,  0,0,0,'0,       0,1, 6,0,  0,'0,       0,'0));     // 32 launch x6 id12
        vecs.push_back(mk(0,0,0,   1,12,6,'h55,    1,1, 6,0,  0,'h55,     0,'0));     // 33 clear+commit
        vecs.push_back(mk(0,0,0,   0,0,0,'0,       0,1, 6,0,  0,'h55,     0,'0));     // 34 value written

        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_in);
            #1;
            _rf_launch_ready = vecs[i].lv; _rf_launch_rob_id = vecs[i].lid;
            _rf_launch_register_id = vecs[i].lrd;
            _rf_commit_ready = vecs[i].cv; _rf_commit_rob_id = vecs[i].cid;
            _rf_commit_register_id = vecs[i].crd; _rf_commit_value = vecs[i].cval;
            _clear = vecs[i].clr; rdy_in = vecs[i].rdy;
            _ask_rd_1 = vecs[i].a1; _ask_rd_2 = vecs[i].a2;
            push_exp(i, vecs[i].d1, vecs[i].v1, vecs[i].d2, vecs[i].v2);
            #3 check_outputs();
        end

        // Reset asserted mid-cycle zeroes state without waiting for a clock edge.
        @(posedge clk_in);
        #1 idle_inputs();
        _rf_launch_ready = 1'b1; _rf_launch_rob_id = 5'd13; _rf_launch_register_id = 5'd7;
        _ask_rd_1 = 5'd7; _ask_rd_2 = 5'd3;
        @(posedge clk_in);
        #1 idle_inputs();
        push_exp(100, 13, '0, 0, 'h1234);
        #3 check_outputs();
        #1 rst_in = 1'b1;
        rdy_in = 1'b0;
        #1;
        push_exp(101, 0, '0, 0, '0);
        check_outputs();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        rdy_in = 1'b1;
        _ask_rd_1 = 5'd4; _ask_rd_2 = 5'd5;
        push_exp(102, 0, '0, 0, '0);
        #3 check_outputs();

        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags for the out-of-order core; it is the responder side of the reorder buffer's launch/commit/dependency-query interface. It holds x0–x31 and, per register, the ROB id of the youngest in-flight writer. It answers two combinational source-operand queries per cycle, records launch renames and retires committed values. It also drops all rename tags on a pipeline flush.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `ROB_ID_W`, 5, ROB id width; id 0 means "no pending writer" (ROB ids run 1..31).

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global ready; state holds when low.
- `_clear`  in  1  flush from ROB (mispredict).
- `_rf_launch_ready`  in  1  rename request valid.
- `_rf_launch_rob_id`  in  ROB_ID_W  ROB id of the launching instruction.
- `_rf_launch_register_id`  in  5  destination register.
- `_rf_commit_ready`  in  1  commit request valid.
- `_rf_commit_rob_id`  in  ROB_ID_W  ROB id being retired.
- `_rf_commit_register_id`  in  5  destination register.
- `_rf_commit_value`  in  XLEN  retired value.
- `_ask_rd_1`, `_ask_rd_2`  in  5  source registers queried.
- `_dep_rd_1`, `_dep_rd_2`  out  ROB_ID_W  pending-writer tag, 0 if none.
- `_dep_value_1`, `_dep_value_2`  out  XLEN  architectural value, meaningful when the tag is 0.

## Operation
State:
- `regs[0:31]` (XLEN) holds architectural values.
- `tag[0:31]` (ROB_ID_W) holds the pending-writer ROB id per register.
- `regs[0]` and `tag[0]` are constant 0. Launch and commit to x0 are ignored.

Launch (`_rf_launch_ready && rdy_in && !_clear`):
- `tag[rd] <= _rf_launch_rob_id` at the next clock edge.

Commit (`_rf_commit_ready && rdy_in`):
- `regs[rd] <= _rf_commit_value`.
- `tag[rd] <= 0` only if `tag[rd] == _rf_commit_rob_id`; a younger rename must survive.

Clear (`_clear && rdy_in`):
- All tags go to 0 at the next edge.
- A concurrent commit still writes its value.
- A concurrent launch is dropped.

Simultaneous launch and commit to the same rd:
- The value is written.
- The tag becomes the launch id, because launch wins over tag clear.

Query (combinational, per port n):
- If `_ask_rd_n == 0`: tag 0, value 0.
- Commit bypass: if `_rf_commit_ready && rdy_in && commit rd == _ask_rd_n != 0 && tag[_ask_rd_n] == _rf_commit_rob_id`, output tag 0 and value `_rf_commit_value`.
- Otherwise output `tag[_ask_rd_n]` and `regs[_ask_rd_n]`.
- A same-cycle launch does not affect the query. Sources are read before the launching instruction's own rename, so an instruction never depends on itself.

`rdy_in` low: no state update. Query outputs remain combinational from current state and do not use the commit bypass.

## Timing
- Reset (async assert, sync release): all regs and tags = 0. Query outputs therefore read 0/0 immediately after reset.
- Query latency: 0 cycles (combinational).
- Launch/commit/clear latency: 1 cycle, effective at the next rising edge.
- Reset asserted mid-operation: state is zeroed immediately regardless of `rdy_in` and the clock.
- No handshake back-pressure: every valid launch/commit is accepted in the cycle presented.

## Structure
- Shared package: `XLEN`, `ROB_ID_W`, `NO_DEP = 0`, `REG_ZERO = 5'd0`.
- One natural sub-module, `rf_read_port`: tag/value lookup plus commit bypass. Instantiate it twice.

## Test plan
1. Reset, query x5/x6 -> dep 0/0, value 0/0.
2. Launch x3 with id 7; next cycle query x3 -> dep 7. Commit x3 id 7 value 0x1234 -> same-cycle query of x3 gives dep 0 and value 0x1234 (bypass). Next cycle it gives dep 0 and value 0x1234 from state.
3. Launch x4 id 2, then launch x4 id 9, then commit x4 id 2 value 0xAA -> regs[x4] = 0xAA and tag stays 9. Query -> dep 9.
4. Launch x8 id 3 in the same cycle as commit x8 id 3 value 5 -> next cycle dep 3, regs[x8] = 5.
5. Launch x1..x10 with ids 1..10, then assert `_clear` together with launch x11 id 11 -> all tags 0, including x11. Values are unchanged.
6. Launch/commit x0 value 0xFFFF -> query x0 gives 0/0. Hold `rdy_in` = 0 during launch x2 id 4 -> tag[x2] stays 0.
